sub_br_32bit: RTL and testbench
===============================

Name: sub_br_32bit

Overview:
- 32-bit borrow-ripple subtractor: computes op1 - op2 - bo and produces a 32-bit difference plus a borrow-out.
- Built as a chain of 1-bit full subtractors; the borrow propagates from bit 0 to bit WIDTH-1.
- Results are registered once, so there is a 1-cycle latency.
- Used as the subtract primitive in the ALU datapath and for multi-word subtraction by chaining the borrow-out into the next word's borrow-in.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is required; the ripple chain must be generated from WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- op1  input  32  minuend, raw bit vector.
- op2  input  32  subtrahend, raw bit vector.
- bo  input  1  borrow-in into bit 0; 1 subtracts an extra 1.
- diff  output  32  registered difference, (op1 - op2 - bo) mod 2^32.
- bi  output  1  registered borrow-out from bit 31; 1 when op1 < op2 + bo as unsigned values.

Behaviour:
- Per bit i, with br0 = bo:
  - d_i = op1_i ^ op2_i ^ br_i
  - br_(i+1) = (~op1_i & op2_i) | (~(op1_i ^ op2_i) & br_i)
- Borrow-out = br_WIDTH.
- Must be built structurally as a ripple of 1-bit cells. No carry-lookahead. Using the "-" operator for the datapath is not allowed.
- Equivalence requirement: {bi, diff} == ({1'b0, op1} - {1'b0, op2} - bo) mod 2^33, i.e. bi = 1 exactly when the 33-bit result is negative.
- Arithmetic is unsigned / two's-complement bit arithmetic only:
  - No sign-magnitude interpretation.
  - No overflow flag.
  - No saturation.
- Timing:
  - Inputs are sampled on every rising clk.
  - diff and bi reflect those inputs after that edge (latency 1, throughput 1 per cycle).
  - No handshake; the block is always enabled.
- Reset:
  - rst_n low asynchronously forces diff = 32'h00000000 and bi = 0, immediately and independent of clk.
  - Outputs hold these values while rst_n is low.
  - First valid result appears on the first rising clk after rst_n deasserts.
  - Reset asserted mid-stream discards any in-flight result.
- Boundary cases:
  - op1 == op2, bo = 0 -> diff 0, bi 0.
  - op1 == op2, bo = 1 -> diff FFFFFFFF, bi 1.
  - 0 - FFFFFFFF - 1 -> diff 00000000, bi 1. Full-length borrow ripple.
  - FFFFFFFF - 0 - 0 -> diff FFFFFFFF, bi 0.
- No X propagation from reset state: outputs are never X after reset, even if inputs are X before the first clock.

Test Plan:
- Reset and forward subtract: rst_n low, then high; outputs 0 during reset.
  - op1=7, op2=4, bo=0 -> diff 00000003, bi 0 one cycle later.
  - op1=7, op2=4, bo=1 -> diff 00000002, bi 0.
- Underflow:
  - op1=4, op2=7, bo=0 -> diff FFFFFFFD, bi 1.
  - op1=4, op2=7, bo=1 -> diff FFFFFFFC, bi 1.
- High bit set:
  - op1=80000007, op2=4, bo=0 -> diff 80000003, bi 0.
  - op1=80000007, op2=4, bo=1 -> diff 80000002, bi 0.
- Full ripple:
  - op1=0, op2=FFFFFFFF, bo=1 -> diff 00000000, bi 1.
  - op1=op2=12345678, bo=1 -> diff FFFFFFFF, bi 1.
- Async reset mid-stream: apply a nonzero result, then drop rst_n between clock edges -> diff 0 and bi 0 immediately, without waiting for clk; they stay 0 until the first edge after release.
- Random: 10k random op1/op2/bo back-to-back each cycle -> every cycle {bi, diff} matches the 33-bit reference model from the previous cycle's inputs.

Source files
------------

// File: rtl/sub_br_32bit.sv
// sub_br_32bit: borrow-ripple subtractor, {bi, diff} = op1 - op2 - bo, one register stage.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears diff and bi
//   op1    minuend
//   op2    subtrahend
//   bo     borrow-in into bit 0
//   diff   registered difference, (op1 - op2 - bo) mod 2^WIDTH
//   bi     registered borrow-out of the top bit

// One-bit full subtractor cell.
module sub_br_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic br_i,
  output logic d_o,
  output logic br_o
);

  logic ab_eq;

  always_comb begin
    ab_eq = ~(a_i ^ b_i);
    d_o   = a_i ^ b_i ^ br_i;
    // Borrow when a < b, or when a == b and a borrow arrives from below.
    br_o  = (~a_i & b_i) | (ab_eq & br_i);
  end

endmodule

module sub_br_32bit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             bo,
  output logic [WIDTH-1:0] diff,
  output logic             bi
);

  logic [WIDTH:0]   br_chain;
  logic [WIDTH-1:0] diff_d;
  logic [WIDTH-1:0] diff_q;
  logic             bi_d;
  logic             bi_q;

  assign br_chain[0] = bo;

  // Ripple chain: bit i borrows from bit i+1 through br_chain[i+1].
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    sub_br_cell u_cell (
      .a_i  (op1[i]),
      .b_i  (op2[i]),
      .br_i (br_chain[i]),
      .d_o  (diff_d[i]),
      .br_o (br_chain[i+1])
    );
  end

  always_comb begin
    bi_d = br_chain[WIDTH];
  end

  // Result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
      bi_q   <= 1'b0;
    end else begin
      diff_q <= diff_d;
      bi_q   <= bi_d;
    end
  end

  assign diff = diff_q;
  assign bi   = bi_q;

endmodule

// File: tb/tb_sub_br_32bit.sv
// Testbench for sub_br_32bit: directed boundary cases, async reset, and random
// back-to-back traffic against a 33-bit arithmetic reference.
module tb_sub_br_32bit;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             bo;
  logic [WIDTH-1:0] diff;
  logic             bi;

  int unsigned n_checks;
  int unsigned n_errors;

  sub_br_32bit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .op1   (op1),
    .op2   (op2),
    .bo    (bo),
    .diff  (diff),
    .bi    (bi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got {bi,diff}=%h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 33-bit unsigned subtraction.
  function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic c);
    logic [WIDTH:0] r;
    r = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(c);
    return r;
  endfunction

  // Drive one vector at the falling edge, check after the next rising edge.
  task automatic run_vec(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic c,
                         input logic [WIDTH:0] exp);
    @(negedge clk);
    op1 = a;
    op2 = b;
    bo  = c;
    @(posedge clk);
    #1;
    check(tag, {bi, diff}, exp);
    check({tag, "_ref"}, {bi, diff}, ref_sub(a, b, c));
  endtask

  initial begin
    logic [WIDTH-1:0] pa, pb;
    logic             pc;
    n_checks = 0;
    n_errors = 0;

    // Reset with undriven inputs: outputs must be clean zeros.
    rst_n = 1'b0;
    op1   = 'x;
    op2   = 'x;
    bo    = 1'bx;
    #1;
    check("reset_async", {bi, diff}, 33'h0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", {bi, diff}, 33'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release", {bi, diff}, 33'h0);

    // Directed cases.
    run_vec("fwd_b0",   32'd7,          32'd4,          1'b0, {1'b0, 32'h00000003});
    run_vec("fwd_b1",   32'd7,          32'd4,          1'b1, {1'b0, 32'h00000002});
    run_vec("under_b0", 32'd4,          32'd7,          1'b0, {1'b1, 32'hFFFFFFFD});
    run_vec("under_b1", 32'd4,          32'd7,          1'b1, {1'b1, 32'hFFFFFFFC});
    run_vec("high_b0",  32'h80000007,   32'd4,          1'b0, {1'b0, 32'h80000003});
    run_vec("high_b1",  32'h80000007,   32'd4,          1'b1, {1'b0, 32'h80000002});
    run_vec("ripple",   32'h00000000,   32'hFFFFFFFF,   1'b1, {1'b1, 32'h00000000});
    run_vec("eq_b1",    32'h12345678,   32'h12345678,   1'b1, {1'b1, 32'hFFFFFFFF});
    run_vec("eq_b0",    32'h12345678,   32'h12345678,   1'b0, {1'b0, 32'h00000000});
    run_vec("max_m0",   32'hFFFFFFFF,   32'h00000000,   1'b0, {1'b0, 32'hFFFFFFFF});

    // Async reset mid-stream: nonzero result, then drop rst_n between edges.
    run_vec("pre_rst",  32'd4,          32'd7,          1'b0, {1'b1, 32'hFFFFFFFD});
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_async", {bi, diff}, 33'h0);
    op1 = 32'hDEADBEEF;
    op2 = 32'h1;
    bo  = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_hold", {bi, diff}, 33'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_release", {bi, diff}, 33'h0);
    @(posedge clk);
    #1;
    check("midrst_first", {bi, diff}, {1'b0, 32'hDEADBEEE});

    // Random back-to-back: each falling edge checks the previous cycle's inputs.
    @(negedge clk);
    pa  = $urandom;
    pb  = $urandom;
    pc  = 1'($urandom_range(1, 0));
    op1 = pa;
    op2 = pb;
    bo  = pc;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      check("random", {bi, diff}, ref_sub(pa, pb, pc));
      case ($urandom_range(7, 0))
        0:       begin pa = $urandom; pb = pa; end
        1:       begin pa = '0; pb = $urandom; end
        2:       begin pa = $urandom; pb = '1; end
        default: begin pa = $urandom; pb = $urandom; end
      endcase
      pc  = 1'($urandom_range(1, 0));
      op1 = pa;
      op2 = pb;
      bo  = pc;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
